// File: rtl/window_5x5_gen.sv
// Streaming 5x5 neighbourhood generator: four line memories plus a 5x5
// shift window, emitting one full window per accepted interior pixel.
module window_5x5_gen #(
    parameter int W = 600,
    parameter int H = 450
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   Din,
    input  logic         data_valid,
    input  logic         sof,
    output logic [199:0] win,
    output logic         win_valid,
    output logic [15:0]  win_x,
    output logic [15:0]  win_y,
    output logic         frame_done
);

    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
    localparam logic [CW-1:0] COL_FOUR = CW'(4);
    localparam logic [RW-1:0] ROW_FOUR = RW'(4);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;

    logic          accept;
    logic          emit;
    logic          last_px;

    logic [7:0]    lm0 [W];
    logic [7:0]    lm1 [W];
    logic [7:0]    lm2 [W];
    logic [7:0]    lm3 [W];
    logic [7:0]    rd0;
    logic [7:0]    rd1;
    logic [7:0]    rd2;
    logic [7:0]    rd3;

    logic [4:0][7:0]  new_col;
    logic [24:0][7:0] wreg;
    logic [24:0][7:0] nxt;

    // sof forces the accepted pixel to (0,0) regardless of the counters
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
    end

    assign accept  = data_valid & ~rst;
    assign emit    = accept & (cur_row >= ROW_FOUR) & (cur_col >= COL_FOUR);
    assign last_px = (cur_row == ROW_LAST) & (cur_col == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (data_valid) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    assign rd0 = lm0[cur_col];
    assign rd1 = lm1[cur_col];
    assign rd2 = lm2[cur_col];
    assign rd3 = lm3[cur_col];

    // Each column address ages by one line; contents are never cleared
    always_ff @(posedge clk) begin
        if (accept) begin
            lm0[cur_col] <= Din;
            lm1[cur_col] <= rd0;
            lm2[cur_col] <= rd1;
            lm3[cur_col] <= rd2;
        end
    end

    assign new_col = {Din, rd0, rd1, rd2, rd3};

    always_comb begin
        nxt = '0;
        for (int dy = 0; dy < 5; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                nxt[5*dy+dx] = wreg[5*dy+dx+1];
            end
            nxt[5*dy+4] = new_col[dy];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wreg <= '0;
        end else if (accept) begin
            wreg <= nxt;
        end
    end

    // win holds the last emitted window; only the pulses drop between events
    always_ff @(posedge clk) begin
        if (rst) begin
            win        <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= emit;
            frame_done <= emit & last_px;
            if (emit) begin
                win   <= nxt;
                win_x <= 16'(cur_col - COL_FOUR);
                win_y <= 16'(cur_row - ROW_FOUR);
            end
        end
    end

endmodule
